// File: rtl/dbus_periph_ctrl.sv
// Data-side controller: byte-writable data RAM plus timer/interrupt register block.
// Define DBUS_SWIRQ_EN to add the software-interrupt register at offset 0x10.
module dbus_periph_ctrl #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Data_addr,
  input  logic [31:0] Wdata,
  input  logic [3:0]  we,
  input  logic        IACK,
  output logic [31:0] Rdata,
  output logic        I_Req
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam logic [5:0] OFF_MTIME  = 6'h00;
  localparam logic [5:0] OFF_CMP    = 6'h01;
  localparam logic [5:0] OFF_CTRL   = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        tpend_q, tpend_d;
  logic        berr_q, berr_d;
  logic [15:0] presc_q, presc_d;
  logic        spend;

  logic          ram_sel, per_sel, per_hit, wr, tick, match;
  logic          sel_mtime, sel_cmp, sel_ctrl, sel_status, sel_swirq;
  logic [5:0]    off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   wmask;
  logic          unused_addr;

  // Address decode on the word address only
  assign ram_sel    = (Data_addr[31:16] == 16'h0000) && (Data_addr[31:2] < 30'(RAM_WORDS));
  assign per_sel    = (Data_addr[31:8] == 24'h000100);
  assign off        = Data_addr[7:2];
  assign ram_idx    = Data_addr[AW+1:2];
  assign sel_mtime  = per_sel && (off == OFF_MTIME);
  assign sel_cmp    = per_sel && (off == OFF_CMP);
  assign sel_ctrl   = per_sel && (off == OFF_CTRL);
  assign sel_status = per_sel && (off == OFF_STATUS);
  assign per_hit    = sel_mtime | sel_cmp | sel_ctrl | sel_status | sel_swirq;
  assign wr         = |we;
  assign wmask      = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign tick       = ctrl_q[0] && (presc_q == 16'(PRESCALE - 1));
  assign match      = (mtime_q == mtimecmp_q);
  assign unused_addr = ^Data_addr[1:0];

`ifdef DBUS_SWIRQ_EN
  logic spend_q, spend_d;

  assign sel_swirq = per_sel && (off == 6'h04);

  // Software pending: set beats both W1C and acknowledge
  always_comb begin
    spend_d = spend_q;
    if (IACK) spend_d = 1'b0;
    if (sel_status && we[0] && Wdata[1]) spend_d = 1'b0;
    if (sel_swirq && we[0] && Wdata[0]) spend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) spend_q <= 1'b0;
    else       spend_q <= spend_d;
  end

  assign spend = spend_q;
`else
  assign sel_swirq = 1'b0;
  assign spend     = 1'b0;
`endif

  // Register next state; later assignments carry higher priority
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    tpend_d    = tpend_q;
    berr_d     = berr_q;
    presc_d    = presc_q;
    if (ctrl_q[0]) presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (tick) mtime_d = (match && ctrl_q[2]) ? 32'd0 : mtime_q + 32'd1;
    if (sel_mtime && wr) begin
      mtime_d = (mtime_q & ~wmask) | (Wdata & wmask);
      presc_d = 16'd0;
    end
    if (sel_cmp && wr) mtimecmp_d = (mtimecmp_q & ~wmask) | (Wdata & wmask);
    if (sel_ctrl && we[0]) ctrl_d = Wdata[2:0];
    if (IACK) tpend_d = 1'b0;
    if (sel_status && we[0]) begin
      if (Wdata[0]) tpend_d = 1'b0;
      if (Wdata[2]) berr_d  = 1'b0;
    end
    if (tick && match) tpend_d = 1'b1;
    if (wr && !ram_sel && !per_hit) berr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= 32'd0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      ctrl_q     <= 3'd0;
      tpend_q    <= 1'b0;
      berr_q     <= 1'b0;
      presc_q    <= 16'd0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      tpend_q    <= tpend_d;
      berr_q     <= berr_d;
      presc_q    <= presc_d;
    end
  end

  // Data RAM keeps its contents across reset; writes in a reset cycle are dropped
  always_ff @(posedge clk) begin
    if (!reset && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) ram_q[ram_idx][8*i +: 8] <= Wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    Rdata = 32'd0;
    if (reset)           Rdata = 32'd0;
    else if (ram_sel)    Rdata = ram_q[ram_idx];
    else if (sel_mtime)  Rdata = mtime_q;
    else if (sel_cmp)    Rdata = mtimecmp_q;
    else if (sel_ctrl)   Rdata = {29'd0, ctrl_q};
    else if (sel_status) Rdata = {29'd0, berr_q, spend, tpend_q};
  end

  assign I_Req = (tpend_q | spend) & ctrl_q[1] & ~IACK;

endmodule

// File: tb/tb_dbus_periph_ctrl.sv
// Directed bench for dbus_periph_ctrl; a second instance with PRESCALE=4 shares the bus inputs.
module tb_dbus_periph_ctrl;

  localparam logic [31:0] PER      = 32'h0001_0000;
  localparam logic [31:0] A_MTIME  = PER + 32'h00;
  localparam logic [31:0] A_CMP    = PER + 32'h04;
  localparam logic [31:0] A_CTRL   = PER + 32'h08;
  localparam logic [31:0] A_STATUS = PER + 32'h0C;
  localparam logic [31:0] A_SWIRQ  = PER + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Data_addr, Wdata;
  logic [3:0]  we;
  logic        IACK;
  logic [31:0] Rdata, Rdata4;
  logic        I_Req, I_Req4;
  logic [31:0] r, r4;
  int          n_checks = 0;
  int          n_errors = 0;

  dbus_periph_ctrl #(.RAM_WORDS(1024), .PRESCALE(1)) u_dut (
    .clk(clk), .reset(reset), .Data_addr(Data_addr), .Wdata(Wdata), .we(we),
    .IACK(IACK), .Rdata(Rdata), .I_Req(I_Req)
  );

  dbus_periph_ctrl #(.RAM_WORDS(1024), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .Data_addr(Data_addr), .Wdata(Wdata), .we(we),
    .IACK(IACK), .Rdata(Rdata4), .I_Req(I_Req4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    Data_addr = a;
    Wdata     = d;
    we        = w;
    @(posedge clk); #1;
    we    = 4'b0000;
    Wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d4);
    Data_addr = a;
    we        = 4'b0000;
    #1;
    d  = Rdata;
    d4 = Rdata4;
  endtask

  task automatic tick_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 4'b0000;
    tick_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Data_addr = A_CMP; Wdata = 32'd0; we = 4'b0000; IACK = 1'b0;
    tick_cycle();
    check("rst_rdata_forced", Rdata, 32'd0);
    tick_cycle();
    check("rst_ireq", {31'd0, I_Req}, 32'd0);
    reset = 1'b0;
    rd(A_MTIME, r, r4);  check("rst_mtime", r, 32'd0);
    rd(A_CMP, r, r4);    check("rst_mtimecmp", r, 32'hFFFF_FFFF);
    rd(A_CTRL, r, r4);   check("rst_ctrl", r, 32'd0);
    rd(A_STATUS, r, r4); check("rst_status", r, 32'd0);

    // RAM byte lanes and read-during-write ordering
    bus_write(32'h40, 32'hAABB_CCDD, 4'b1111);
    bus_write(32'h40, 32'h00EE_0000, 4'b0100);
    rd(32'h40, r, r4); check("ram_byte_lane", r, 32'hAAEE_CCDD);
    Data_addr = 32'h40; Wdata = 32'h1122_3344; we = 4'b1111; #1;
    check("ram_same_cycle_old", Rdata, 32'hAAEE_CCDD);
    tick_cycle(); we = 4'b0000;
    rd(32'h40, r, r4); check("ram_next_cycle_new", r, 32'h1122_3344);
    bus_write(32'hFFC, 32'h0BAD_F00D, 4'b1111);
    rd(32'hFFC, r, r4); check("ram_last_word", r, 32'h0BAD_F00D);

    // Unmapped accesses and bus error
    bus_write(32'h0, 32'hCAFE_F00D, 4'b1111);
    bus_write(32'h0002_0000, 32'h1234_5678, 4'b1111);
    rd(A_STATUS, r, r4);     check("berr_set", r, 32'h4);
    rd(32'h0, r, r4);        check("berr_ram_untouched", r, 32'hCAFE_F00D);
    rd(32'h0002_0000, r, r4); check("unmapped_read", r, 32'd0);
    bus_write(A_STATUS, 32'h4, 4'b0001);
    rd(A_STATUS, r, r4);     check("berr_w1c", r, 32'd0);
    bus_write(32'h1000, 32'h5555_5555, 4'b1111);
    rd(A_STATUS, r, r4);     check("berr_ram_past_end", r, 32'h4);
    rd(32'h1000, r, r4);     check("ram_past_end_read", r, 32'd0);
    rd(32'h0, r, r4);        check("ram_past_end_no_alias", r, 32'hCAFE_F00D);
    bus_write(A_STATUS, 32'h4, 4'b0001);
    Data_addr = PER + 32'h14; tick_cycle();
    check("unmapped_per_read", Rdata, 32'd0);
    rd(A_STATUS, r, r4);     check("read_no_berr", r, 32'd0);
    bus_write(PER + 32'h14, 32'h1, 4'b1111);
    rd(A_STATUS, r, r4);     check("berr_per_unmapped", r, 32'h4);
    bus_write(A_STATUS, 32'h4, 4'b0001);

    // Timer match with IACK handshake
    do_reset();
    bus_write(A_CMP, 32'd5, 4'b1111);
    bus_write(A_CTRL, 32'h3, 4'b0001);
    rd(A_MTIME, r, r4); check("tm_mtime_start", r, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick_cycle();
      rd(A_MTIME, r, r4); check("tm_mtime_count", r, 32'(k));
    end
    rd(A_STATUS, r, r4); check("tm_no_pend_yet", r, 32'd0);
    check("tm_ireq_low", {31'd0, I_Req}, 32'd0);
    tick_cycle();
    rd(A_STATUS, r, r4); check("tm_tpend", r, 32'h1);
    check("tm_ireq_high", {31'd0, I_Req}, 32'd1);
    rd(A_MTIME, r, r4);  check("tm_mtime_past_match", r, 32'd6);
    for (int k = 0; k < 3; k++) begin
      tick_cycle();
      check("tm_ireq_hold", {31'd0, I_Req}, 32'd1);
    end
    IACK = 1'b1; #1;
    check("tm_ireq_drop_on_iack", {31'd0, I_Req}, 32'd0);
    tick_cycle(); IACK = 1'b0;
    rd(A_STATUS, r, r4); check("tm_status_cleared", r, 32'd0);
    check("tm_ireq_after_ack", {31'd0, I_Req}, 32'd0);

    // Auto-reload on both prescale settings
    do_reset();
    bus_write(A_CMP, 32'd3, 4'b1111);
    bus_write(A_CTRL, 32'h7, 4'b0001);
    for (int k = 1; k <= 16; k++) begin
      tick_cycle();
      rd(A_MTIME, r, r4);
      check("ar_mtime_p1", r, 32'(k % 4));
      check("ar_mtime_p4", r4, 32'((k / 4) % 4));
      if (k == 3) begin rd(A_STATUS, r, r4); check("ar_no_pend", r, 32'd0); end
      if (k == 4) begin rd(A_STATUS, r, r4); check("ar_pend", r, 32'h1); end
    end

    // Collisions: W1C vs match, MTIME write vs tick
    do_reset();
    bus_write(A_CMP, 32'd2, 4'b1111);
    bus_write(A_CTRL, 32'h1, 4'b0001);
    tick_cycle();
    tick_cycle();
    rd(A_MTIME, r, r4); check("col_mtime_pre", r, 32'd2);
    bus_write(A_STATUS, 32'h1, 4'b0001);
    rd(A_STATUS, r, r4); check("col_w1c_vs_match", r, 32'h1);
    rd(A_MTIME, r, r4);  check("col_mtime_match", r, 32'd3);
    tick_cycle();
    bus_write(A_MTIME, 32'h100, 4'b1111);
    rd(A_MTIME, r, r4);
    check("col_mtime_write_p1", r, 32'h100);
    check("col_mtime_write_p4", r4, 32'h100);
    tick_cycle();
    rd(A_MTIME, r, r4); check("col_mtime_inc", r, 32'h101);
    tick_cycle(); tick_cycle();
    rd(A_MTIME, r, r4); check("col_presc_cleared", r4, 32'h100);
    tick_cycle();
    rd(A_MTIME, r, r4); check("col_presc_tick", r4, 32'h101);
    check("col_ireq_ie_off", {31'd0, I_Req}, 32'd0);
    bus_write(A_CTRL, 32'h2, 4'b0001);
    check("col_ireq_ie_on", {31'd0, I_Req}, 32'd1);

    // Reset mid-request drops I_Req and discards the in-flight write
    reset = 1'b1; Data_addr = 32'h40; Wdata = 32'hDEAD_BEEF; we = 4'b1111; #1;
    check("rst_mid_rdata", Rdata, 32'd0);
    tick_cycle();
    check("rst_mid_ireq", {31'd0, I_Req}, 32'd0);
    reset = 1'b0; we = 4'b0000;
    rd(32'h40, r, r4);   check("rst_mid_write_dropped", r, 32'h1122_3344);
    rd(A_CMP, r, r4);    check("rst_mid_mtimecmp", r, 32'hFFFF_FFFF);
    rd(A_STATUS, r, r4); check("rst_mid_status", r, 32'd0);

    // Software interrupt
    bus_write(A_CTRL, 32'h2, 4'b0001);
    bus_write(A_SWIRQ, 32'h1, 4'b0001);
`ifdef DBUS_SWIRQ_EN
    rd(A_STATUS, r, r4); check("sw_spend", r, 32'h2);
    check("sw_ireq", {31'd0, I_Req}, 32'd1);
    rd(A_SWIRQ, r, r4);  check("sw_reads_zero", r, 32'd0);
    IACK = 1'b1; #1;
    check("sw_ireq_ack", {31'd0, I_Req}, 32'd0);
    tick_cycle(); IACK = 1'b0;
    rd(A_STATUS, r, r4); check("sw_spend_cleared", r, 32'd0);
`else
    rd(A_STATUS, r, r4); check("sw_absent_berr", r, 32'h4);
    check("sw_absent_ireq", {31'd0, I_Req}, 32'd0);
    rd(A_SWIRQ, r, r4);  check("sw_absent_read", r, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbus_periph_ctrl.md
# dbus_periph_ctrl

Data-side memory and peripheral controller sitting directly downstream of the pipelined RISC-V core's MEM stage. It consumes the core's `Data_addr`/`Wdata`/`we` and returns `Rdata` combinationally within the same cycle. It decodes the address into a byte-writable data RAM plus a memory-mapped timer/interrupt register block. It drives the core's `I_Req` input and consumes `IACK` in a request/acknowledge handshake.

## Interface
- `RAM_WORDS`, default 1024: data RAM depth in 32-bit words; power of two, at least 4.
- `PRESCALE`, default 1: timer tick period in clock cycles; range 1..65535.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `Data_addr`  in  32  — byte address from the core MEM stage; only `[31:2]` is decoded.
- `Wdata`  in  32  — store data, already lane-aligned by the core.
- `we`  in  4  — per-byte write enables, already lane-aligned; `4'b0000` means read or idle.
- `IACK`  in  1  — interrupt acknowledge from the core.
- `Rdata`  out  32  — full read word, combinational from `Data_addr`; the core extracts bytes and halfwords itself.
- `I_Req`  out  1  — interrupt request to the core.

## Operation
- **Address decode:**
  - RAM region: `Data_addr[31:16]==16'h0000` and word index `Data_addr[31:2] < RAM_WORDS`.
  - Peripheral region: `Data_addr[31:8]==24'h000100`.
  - Everything else is unmapped.
- **RAM:**
  - Writes: each byte lane i is written at the clock edge when `we[i]=1`.
  - Reads: asynchronous.
  - Contents are not cleared by reset.
- **Peripheral registers** (offset = `Data_addr[7:0]`; byte lanes honoured on every write):
  - 0x00 MTIME: read/write counter. A CPU write overrides the tick update in the same cycle and clears the prescaler.
  - 0x04 MTIMECMP: read/write compare value.
  - 0x08 CTRL, read/write:
    - bit0 TEN: timer enable.
    - bit1 IE: interrupt enable.
    - bit2 AR: auto-reload.
    - Other bits read 0.
  - 0x0C STATUS, write-1-to-clear:
    - bit0 TPEND: timer pending.
    - bit1 SPEND: software pending.
    - bit2 BERR: bus error.
  - 0x10 SWIRQ: see Configuration.
  - Other peripheral offsets are unmapped.
- **Unmapped access:**
  - Read returns 0.
  - A write (`we != 0`) is discarded and sets BERR.
  - Reads never set BERR.
- **Prescaler:**
  - 16-bit counter that runs only while TEN=1.
  - A tick fires in the cycle the counter equals `PRESCALE-1`; the counter then returns to 0.
  - With `PRESCALE=1`, every TEN cycle is a tick.
- **On a tick:**
  - If MTIME==MTIMECMP: set TPEND, and load MTIME with AR ? 0 : MTIME+1.
  - Otherwise MTIME <= MTIME+1, wrapping 0xFFFFFFFF to 0.
- **Interrupt:**
  - `I_Req = (TPEND | SPEND) & IE & ~IACK` (combinational).
  - At each edge where IACK=1, TPEND and SPEND are cleared.
  - I_Req stays asserted across core stall cycles until IACK rises, and never overlaps IACK. This guarantees exactly one acknowledged interrupt per pending event.
- **Priority when events coincide in one cycle:**
  - A set event (tick match, SWIRQ write) beats a W1C clear and beats IACK clear.
  - A CPU write to MTIME beats the tick increment.
- **Reset values:**
  - Output `I_Req` 0; `Rdata` is forced to 0 while reset=1.
  - MTIME 0, MTIMECMP 0xFFFFFFFF, CTRL 0, STATUS 0, prescaler 0.

## Timing
- **Read latency:** 0 cycles. `Rdata` is valid in the same cycle `Data_addr` is presented, and is sampled by the core's MEM/WB register at the next edge.
- **Write latency:**
  - Effective at the edge ending the cycle `we` is asserted.
  - A read of the same word in the following cycle returns the new data.
  - A same-cycle read returns the old data.
- **Timer events:**
  - A TPEND set at edge N raises I_Req in cycle N+1 (if IE=1).
  - Setting IE=1 while already pending raises I_Req the cycle after the CTRL write edge.
- **Interrupt handshake:**
  - The IACK rise drops I_Req combinationally in that same cycle.
  - Pending bits are 0 after that edge.
  - A new event may re-raise I_Req no earlier than the cycle after IACK falls.
- **Reset mid-operation:** state returns to the reset values at the next edge; any in-flight write in the reset cycle is discarded.

## Configuration
- `DBUS_SWIRQ_EN` defined:
  - Offset 0x10 SWIRQ is write-only and reads 0.
  - Writing with `we[0]=1` and `Wdata[0]=1` sets SPEND.
- `DBUS_SWIRQ_EN` undefined:
  - Offset 0x10 is unmapped; writes set BERR.
  - SPEND is constant 0 and the SPEND logic is absent.

## Test plan
- **RAM byte lanes:** write 0xAABBCCDD to 0x40 with `we=4'b1111`, then `we=4'b0100` with `Wdata=0x00EE0000` → read 0x40 returns 0xAAEECCDD.
- **Timer match:**
  - Stimulus: `PRESCALE=1`; MTIMECMP=5; CTRL=0x3.
  - MTIME counts 0..5; TPEND set at the match edge; I_Req=1 next cycle.
  - Hold IACK=0 for 3 cycles → I_Req stays 1.
  - Drive IACK=1 → I_Req=0 that cycle, STATUS reads 0 after.
- **Auto-reload:** CTRL=0x7, MTIMECMP=3 → MTIME sequence 0,1,2,3,0,1..., with TPEND set every 4th tick. `PRESCALE=4` stretches each step to 4 cycles.
- **Collisions:**
  - STATUS W1C of bit0 in the same cycle as a match → TPEND remains 1.
  - MTIME write of 0x100 during a tick → MTIME reads 0x100.
- **Bus error:**
  - Write to 0x0002_0000 → BERR=1, no RAM change.
  - Read of 0x0002_0000 → Rdata=0.
  - Writing 0x4 to STATUS → BERR=0.
- **Software IRQ:**
  - With `DBUS_SWIRQ_EN`: write 1 to 0x0001_0010 with IE=1 → SPEND=1, then I_Req=1.
  - Without it: same write → BERR=1, I_Req stays 0.
  - Reset mid-request → I_Req=0 the next cycle.
